// File: rtl/noc_rv_bridge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rv_bridge_pkg : shared defaults, flit type and helpers for the bridge
// Rev 1.0
// ---------------------------------------------------------------------------
package noc_rv_bridge_pkg;

  localparam int NOC_DATA_WIDTH_DEF = 64;
  localparam int C2B_DEPTH_DEF      = 4;
  localparam int B2C_CREDITS_DEF    = 8;

  typedef logic [NOC_DATA_WIDTH_DEF-1:0] flit_t;

  // Bits needed to hold every value 0..credits inclusive.
  function automatic int credit_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_rv_bridge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rv_bridge_if : one channel's NoC credit port plus its rx/tx streams
// Rev 1.0
// ---------------------------------------------------------------------------
interface noc_rv_bridge_if
  import noc_rv_bridge_pkg::*;
#(
  parameter int NOC_DATA_WIDTH = NOC_DATA_WIDTH_DEF
);

  logic                      c2b_valid;
  logic [NOC_DATA_WIDTH-1:0] c2b_data;
  logic                      c2b_yummy;
  logic                      b2c_valid;
  logic [NOC_DATA_WIDTH-1:0] b2c_data;
  logic                      b2c_yummy;
  logic                      rx_valid;
  logic [NOC_DATA_WIDTH-1:0] rx_data;
  logic                      rx_ready;
  logic                      tx_valid;
  logic [NOC_DATA_WIDTH-1:0] tx_data;
  logic                      tx_ready;

  // slave = the bridge, master = chip + fabric environment
  modport slave (
    input  c2b_valid, c2b_data, b2c_yummy, rx_ready, tx_valid, tx_data,
    output c2b_yummy, b2c_valid, b2c_data, rx_valid, rx_data, tx_ready
  );

  modport master (
    output c2b_valid, c2b_data, b2c_yummy, rx_ready, tx_valid, tx_data,
    input  c2b_yummy, b2c_valid, b2c_data, rx_valid, rx_data, tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/noc_rv_bridge_chan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rv_bridge_chan : one c2b receive FIFO and one b2c credit sender
// Optional statistics under NOC_RV_BRIDGE_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module noc_rv_bridge_chan
  import noc_rv_bridge_pkg::*;
#(
  parameter int NOC_DATA_WIDTH = NOC_DATA_WIDTH_DEF,
  parameter int C2B_DEPTH      = C2B_DEPTH_DEF,
  parameter int B2C_CREDITS    = B2C_CREDITS_DEF
)(
  input  wire logic      clock,
  input  wire logic      rst_n,
  noc_rv_bridge_if.slave bus,
  output logic           o_err
`ifdef NOC_RV_BRIDGE_STATS_EN
  ,
  output logic [31:0]    o_stat_rx_cnt,
  output logic [31:0]    o_stat_tx_cnt
`endif
);

  localparam int c_PTR_W = $clog2(C2B_DEPTH);
  localparam int c_CNT_W = $clog2(C2B_DEPTH + 1);
  localparam int c_CRD_W = credit_w(B2C_CREDITS);
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(C2B_DEPTH);
  localparam logic [c_CRD_W-1:0] c_CRD_MAX = c_CRD_W'(B2C_CREDITS);

  logic [NOC_DATA_WIDTH-1:0] r_mem [C2B_DEPTH];
  logic [c_PTR_W-1:0]        r_wptr;
  logic [c_PTR_W-1:0]        r_rptr;
  logic [c_CNT_W-1:0]        r_count;
  logic                      r_yummy;
  logic [c_CRD_W-1:0]        r_credits;
  logic                      r_b2c_valid;
  logic [NOC_DATA_WIDTH-1:0] r_b2c_data;
  logic                      r_err;

  logic w_empty, w_full, w_pop, w_push, w_drop;
  logic w_tx_ready, w_xfer, w_crd_ovr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_pop   = !w_empty && bus.rx_ready;
  // A full FIFO still takes a flit when the head leaves in the same cycle.
  assign w_push  = bus.c2b_valid && (!w_full || w_pop);
  assign w_drop  = bus.c2b_valid && w_full && !w_pop;

  assign w_tx_ready = (r_credits != '0) && rst_n;
  assign w_xfer     = bus.tx_valid && w_tx_ready;
  assign w_crd_ovr  = bus.b2c_yummy && !w_xfer && (r_credits == c_CRD_MAX);

  assign bus.rx_valid  = !w_empty;
  assign bus.rx_data   = r_mem[r_rptr];
  assign bus.c2b_yummy = r_yummy;
  assign bus.b2c_valid = r_b2c_valid;
  assign bus.b2c_data  = r_b2c_data;
  assign bus.tx_ready  = w_tx_ready;
  assign o_err         = r_err;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.c2b_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_yummy <= 1'b0;
    end else begin
      r_yummy <= w_pop;
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_credits   <= c_CRD_MAX;
      r_b2c_valid <= 1'b0;
      r_b2c_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_b2c_valid <= w_xfer;
      if (w_xfer) r_b2c_data <= bus.tx_data;
      if (w_xfer && !bus.b2c_yummy) begin
        r_credits <= r_credits - c_CRD_W'(1);
      end else if (!w_xfer && bus.b2c_yummy && !w_crd_ovr) begin
        r_credits <= r_credits + c_CRD_W'(1);
      end
      r_err <= r_err | w_drop | w_crd_ovr;
    end
  end

`ifdef NOC_RV_BRIDGE_STATS_EN
  logic [31:0] r_stat_rx;
  logic [31:0] r_stat_tx;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_rx <= '0;
      r_stat_tx <= '0;
    end else begin
      if (w_pop)  r_stat_rx <= r_stat_rx + 32'd1;
      if (w_xfer) r_stat_tx <= r_stat_tx + 32'd1;
    end
  end

  assign o_stat_rx_cnt = r_stat_rx;
  assign o_stat_tx_cnt = r_stat_tx;
`endif

endmodule
`default_nettype wire

// File: rtl/noc_rv_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rv_bridge : three independent NoC credit <-> ready/valid channels
// Optional statistics under NOC_RV_BRIDGE_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module noc_rv_bridge
  import noc_rv_bridge_pkg::*;
#(
  parameter int NOC_DATA_WIDTH = NOC_DATA_WIDTH_DEF,
  parameter int C2B_DEPTH      = C2B_DEPTH_DEF,
  parameter int B2C_CREDITS    = B2C_CREDITS_DEF
)(
  input  wire logic      clock,
  input  wire logic      rst_n,
  noc_rv_bridge_if.slave noc1,
  noc_rv_bridge_if.slave noc2,
  noc_rv_bridge_if.slave noc3,
  output logic           err
`ifdef NOC_RV_BRIDGE_STATS_EN
  ,
  output logic [31:0]    stat_rx1_cnt,
  output logic [31:0]    stat_tx1_cnt,
  output logic [31:0]    stat_rx2_cnt,
  output logic [31:0]    stat_tx2_cnt,
  output logic [31:0]    stat_rx3_cnt,
  output logic [31:0]    stat_tx3_cnt
`endif
);

  logic w_err1, w_err2, w_err3;

  noc_rv_bridge_chan #(
    .NOC_DATA_WIDTH (NOC_DATA_WIDTH),
    .C2B_DEPTH      (C2B_DEPTH),
    .B2C_CREDITS    (B2C_CREDITS)
  ) u_chan1 (
    .clock         (clock),
    .rst_n         (rst_n),
    .bus           (noc1),
    .o_err         (w_err1)
`ifdef NOC_RV_BRIDGE_STATS_EN
    ,
    .o_stat_rx_cnt (stat_rx1_cnt),
    .o_stat_tx_cnt (stat_tx1_cnt)
`endif
  );

  noc_rv_bridge_chan #(
    .NOC_DATA_WIDTH (NOC_DATA_WIDTH),
    .C2B_DEPTH      (C2B_DEPTH),
    .B2C_CREDITS    (B2C_CREDITS)
  ) u_chan2 (
    .clock         (clock),
    .rst_n         (rst_n),
    .bus           (noc2),
    .o_err         (w_err2)
`ifdef NOC_RV_BRIDGE_STATS_EN
    ,
    .o_stat_rx_cnt (stat_rx2_cnt),
    .o_stat_tx_cnt (stat_tx2_cnt)
`endif
  );

  noc_rv_bridge_chan #(
    .NOC_DATA_WIDTH (NOC_DATA_WIDTH),
    .C2B_DEPTH      (C2B_DEPTH),
    .B2C_CREDITS    (B2C_CREDITS)
  ) u_chan3 (
    .clock         (clock),
    .rst_n         (rst_n),
    .bus           (noc3),
    .o_err         (w_err3)
`ifdef NOC_RV_BRIDGE_STATS_EN
    ,
    .o_stat_rx_cnt (stat_rx3_cnt),
    .o_stat_tx_cnt (stat_tx3_cnt)
`endif
  );

  assign err = w_err1 | w_err2 | w_err3;

endmodule
`default_nettype wire

// File: tb/tb_noc_rv_bridge.sv
`default_nettype none
// tb_noc_rv_bridge : directed plan items plus randomized traffic, checked every
// cycle against a queue/counter model of the three channels.
module tb_noc_rv_bridge;
  import noc_rv_bridge_pkg::*;

  localparam int W     = 64;
  localparam int DEPTH = 4;
  localparam int CRED  = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  noc_rv_bridge_if #(.NOC_DATA_WIDTH(W)) n1 ();
  noc_rv_bridge_if #(.NOC_DATA_WIDTH(W)) n2 ();
  noc_rv_bridge_if #(.NOC_DATA_WIDTH(W)) n3 ();

  logic       err;
  logic [2:0] c2b_v = '0, b2c_y = '0, rx_rdy = '0, tx_v = '0;
  flit_t      c2b_d [3];
  flit_t      tx_d  [3];
  logic [2:0] c2b_y, b2c_v, rx_v, tx_rdy;
  flit_t      b2c_d [3];
  flit_t      rx_d  [3];

  assign n1.c2b_valid = c2b_v[0]; assign n1.c2b_data = c2b_d[0]; assign n1.b2c_yummy = b2c_y[0];
  assign n1.rx_ready  = rx_rdy[0]; assign n1.tx_valid = tx_v[0]; assign n1.tx_data   = tx_d[0];
  assign n2.c2b_valid = c2b_v[1]; assign n2.c2b_data = c2b_d[1]; assign n2.b2c_yummy = b2c_y[1];
  assign n2.rx_ready  = rx_rdy[1]; assign n2.tx_valid = tx_v[1]; assign n2.tx_data   = tx_d[1];
  assign n3.c2b_valid = c2b_v[2]; assign n3.c2b_data = c2b_d[2]; assign n3.b2c_yummy = b2c_y[2];
  assign n3.rx_ready  = rx_rdy[2]; assign n3.tx_valid = tx_v[2]; assign n3.tx_data   = tx_d[2];

  assign c2b_y[0] = n1.c2b_yummy; assign b2c_v[0] = n1.b2c_valid; assign b2c_d[0] = n1.b2c_data;
  assign rx_v[0]  = n1.rx_valid;  assign rx_d[0]  = n1.rx_data;   assign tx_rdy[0] = n1.tx_ready;
  assign c2b_y[1] = n2.c2b_yummy; assign b2c_v[1] = n2.b2c_valid; assign b2c_d[1] = n2.b2c_data;
  assign rx_v[1]  = n2.rx_valid;  assign rx_d[1]  = n2.rx_data;   assign tx_rdy[1] = n2.tx_ready;
  assign c2b_y[2] = n3.c2b_yummy; assign b2c_v[2] = n3.b2c_valid; assign b2c_d[2] = n3.b2c_data;
  assign rx_v[2]  = n3.rx_valid;  assign rx_d[2]  = n3.rx_data;   assign tx_rdy[2] = n3.tx_ready;

`ifdef NOC_RV_BRIDGE_STATS_EN
  logic [31:0] s_rx [3];
  logic [31:0] s_tx [3];
`endif

  noc_rv_bridge #(
    .NOC_DATA_WIDTH (W),
    .C2B_DEPTH      (DEPTH),
    .B2C_CREDITS    (CRED)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .noc1  (n1),
    .noc2  (n2),
    .noc3  (n3),
    .err   (err)
`ifdef NOC_RV_BRIDGE_STATS_EN
    ,
    .stat_rx1_cnt (s_rx[0]), .stat_tx1_cnt (s_tx[0]),
    .stat_rx2_cnt (s_rx[1]), .stat_tx2_cnt (s_tx[1]),
    .stat_rx3_cnt (s_rx[2]), .stat_tx3_cnt (s_tx[2])
`endif
  );

  // ---------------- behavioural model ----------------
  flit_t       m_q [3][$];
  int          m_cred [3];
  bit          m_yum [3];
  bit          m_bv [3];
  flit_t       m_bd [3];
  bit          m_err;
  int unsigned m_rxcnt [3];
  int unsigned m_txcnt [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic m_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_q[ch].delete();
      m_cred[ch]  = CRED;
      m_yum[ch]   = 1'b0;
      m_bv[ch]    = 1'b0;
      m_bd[ch]    = '0;
      m_rxcnt[ch] = 0;
      m_txcnt[ch] = 0;
    end
    m_err = 1'b0;
  endtask

  // One clock edge of all three channels, from the rules alone.
  task automatic m_step();
    for (int ch = 0; ch < 3; ch++) begin
      bit pop, xfer;
      pop = (m_q[ch].size() != 0) && rx_rdy[ch];
      m_yum[ch] = pop;
      if (pop) begin
        void'(m_q[ch].pop_front());
        m_rxcnt[ch]++;
      end
      if (c2b_v[ch]) begin
        if (m_q[ch].size() < DEPTH) m_q[ch].push_back(c2b_d[ch]);
        else m_err = 1'b1;
      end
      xfer = tx_v[ch] && (m_cred[ch] > 0);
      m_bv[ch] = xfer;
      if (xfer) begin
        m_bd[ch] = tx_d[ch];
        m_cred[ch]--;
        m_txcnt[ch]++;
      end
      if (b2c_y[ch]) begin
        if (!xfer && m_cred[ch] == CRED) m_err = 1'b1;
        else m_cred[ch]++;
      end
    end
  endtask

  always @(posedge clock) if (rst_n) m_step();
  always @(negedge rst_n) m_reset();

  task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %h expected %h at %0t", name, ch, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int ch = 0; ch < 3; ch++) begin
        chk("rx_valid", ch, 64'(rx_v[ch]), 64'(m_q[ch].size() != 0));
        if (m_q[ch].size() != 0) chk("rx_data", ch, rx_d[ch], m_q[ch][0]);
        chk("c2b_yummy", ch, 64'(c2b_y[ch]), 64'(m_yum[ch]));
        chk("b2c_valid", ch, 64'(b2c_v[ch]), 64'(m_bv[ch]));
        chk("b2c_data", ch, b2c_d[ch], m_bd[ch]);
        chk("tx_ready", ch, 64'(tx_rdy[ch]), 64'((m_cred[ch] != 0) && rst_n));
`ifdef NOC_RV_BRIDGE_STATS_EN
        chk("stat_rx", ch, 64'(s_rx[ch]), 64'(m_rxcnt[ch]));
        chk("stat_tx", ch, 64'(s_tx[ch]), 64'(m_txcnt[ch]));
`endif
      end
      chk("err", 0, 64'(err), 64'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    c2b_v = '0; b2c_y = '0; rx_rdy = '0; tx_v = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c2b_d[ch] = '0;
      tx_d[ch]  = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic rand_seg(input int cycles, input bit legal);
    for (int i = 0; i < cycles; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        c2b_v[ch]  = ($urandom_range(0, 99) < 50);
        if (legal && m_q[ch].size() >= DEPTH) c2b_v[ch] = 1'b0;
        c2b_d[ch]  = {$urandom, $urandom};
        rx_rdy[ch] = ($urandom_range(0, 99) < 55);
        tx_v[ch]   = ($urandom_range(0, 99) < 50);
        tx_d[ch]   = {$urandom, $urandom};
        b2c_y[ch]  = ($urandom_range(0, 99) < 40);
        if (legal && m_cred[ch] >= CRED) b2c_y[ch] = 1'b0;
      end
      step();
    end
    idle_inputs();
  endtask

  int cnt;

  initial begin
    idle_inputs();
    m_reset();
    chk_en = 1'b1;

    // Reset state and release
    step();
    step();
    chk("lit_rst_tx_ready", 0, 64'(tx_rdy[0]), 64'd0);
    chk("lit_rst_b2c_valid", 0, 64'(b2c_v[0]), 64'd0);
    chk("lit_rst_yummy", 0, 64'(c2b_y[0]), 64'd0);
    chk("lit_rst_err", 0, 64'(err), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("lit_rel_tx_ready", 0, 64'(tx_rdy[0]), 64'd1);
    chk("lit_model_cred", 0, 64'(m_cred[0]), 64'd8);
    step();

    // c2b single flit on noc1
    c2b_v[0] = 1'b1; c2b_d[0] = 64'hDEAD_BEEF_0000_0001; rx_rdy[0] = 1'b1;
    step();
    c2b_v[0] = 1'b0;
    chk("lit_single_rx_valid", 0, 64'(rx_v[0]), 64'd1);
    chk("lit_single_rx_data", 0, rx_d[0], 64'hDEAD_BEEF_0000_0001);
    chk("lit_single_yummy_pre", 0, 64'(c2b_y[0]), 64'd0);
    step();
    chk("lit_single_yummy", 0, 64'(c2b_y[0]), 64'd1);
    chk("lit_single_empty", 0, 64'(rx_v[0]), 64'd0);
    step();
    chk("lit_single_yummy_off", 0, 64'(c2b_y[0]), 64'd0);
    rx_rdy[0] = 1'b0;

    // c2b backpressure and overflow on noc2
    for (int i = 0; i < 5; i++) begin
      c2b_v[1] = 1'b1; c2b_d[1] = 64'h10 + 64'(i);
      step();
      chk("lit_bp_no_yummy", 1, 64'(c2b_y[1]), 64'd0);
    end
    c2b_v[1] = 1'b0;
    chk("lit_bp_err", 1, 64'(err), 64'd1);
    rx_rdy[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("lit_bp_order", 1, rx_d[1], 64'h10 + 64'(i));
      step();
    end
    chk("lit_bp_drained", 1, 64'(rx_v[1]), 64'd0);
    rx_rdy[1] = 1'b0;

    do_reset();

    // b2c credit exhaustion on noc3
    cnt = 0;
    tx_v[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tx_d[2] = 64'h300 + 64'(i);
      step();
      if (b2c_v[2]) cnt++;
      if (i == 0) chk("lit_exh_first_data", 2, b2c_d[2], 64'h300);
    end
    chk("lit_exh_count", 2, 64'(cnt), 64'd8);
    chk("lit_exh_tx_ready", 2, 64'(tx_rdy[2]), 64'd0);
    chk("lit_exh_last_data", 2, b2c_d[2], 64'h307);
    b2c_y[2] = 1'b1;
    step();
    b2c_y[2] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (b2c_v[2]) cnt++;
    end
    chk("lit_exh_one_more", 2, 64'(cnt), 64'd1);
    tx_v[2] = 1'b0;

    // Simultaneous yummy and transfer on noc1 at 3 credits, then overrun
    tx_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tx_v[0] = 1'b0;
    chk("lit_model_cred3", 0, 64'(m_cred[0]), 64'd3);
    tx_v[0] = 1'b1; b2c_y[0] = 1'b1;
    step();
    tx_v[0] = 1'b0; b2c_y[0] = 1'b0;
    step();
    chk("lit_model_cred3b", 0, 64'(m_cred[0]), 64'd3);
    cnt = 0;
    tx_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b2c_v[0]) cnt++;
    end
    tx_v[0] = 1'b0;
    chk("lit_simul_cred", 0, 64'(cnt), 64'd3);
    b2c_y[0] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("lit_no_err_yet", 0, 64'(err), 64'd0);
    step();
    b2c_y[0] = 1'b0;
    chk("lit_overrun_err", 0, 64'(err), 64'd1);
    cnt = 0;
    tx_v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (b2c_v[0]) cnt++;
    end
    tx_v[0] = 1'b0;
    chk("lit_overrun_cred8", 0, 64'(cnt), 64'd8);

    do_reset();

    // Asynchronous reset mid-transfer on noc2
    c2b_v[1] = 1'b1; tx_v[1] = 1'b1;
    c2b_d[1] = 64'hA1; tx_d[1] = 64'hB1;
    step();
    c2b_d[1] = 64'hA2; tx_d[1] = 64'hB2;
    step();
    c2b_v[1] = 1'b0; tx_d[1] = 64'hB3;
    step();
    tx_v[1] = 1'b0;
    chk("lit_ar_pre_rx", 1, 64'(rx_v[1]), 64'd1);
    chk("lit_ar_pre_bv", 1, 64'(b2c_v[1]), 64'd1);
    chk("lit_model_cred5", 1, 64'(m_cred[1]), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_ar_rx_valid", 1, 64'(rx_v[1]), 64'd0);
    chk("lit_ar_b2c_valid", 1, 64'(b2c_v[1]), 64'd0);
    chk("lit_ar_tx_ready", 1, 64'(tx_rdy[1]), 64'd0);
    chk("lit_ar_err", 1, 64'(err), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("lit_ar_rel_ready", 1, 64'(tx_rdy[1]), 64'd1);
    step();
    cnt = 0;
    tx_v[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (b2c_v[1]) cnt++;
    end
    tx_v[1] = 1'b0;
    chk("lit_ar_cred8", 1, 64'(cnt), 64'd8);

    // Randomized traffic: protocol-legal, then unconstrained
    do_reset();
    rand_seg(600, 1'b1);
    chk("lit_legal_no_err", 0, 64'(err), 64'd0);
    do_reset();
    rand_seg(600, 1'b0);
    step();
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
